ym_bus_ctrl: RTL
================

Name: ym_bus_ctrl

Overview:
Sequences CPU-side register accesses onto the shared BDIR/BC1/DA bus of the two YM2149 chips in the TurboSound pair.
- Accepts address-latch, data-write and data-read requests over a valid/ready handshake.
- Generates timed setup, strobe and hold phases on the bus.
- Owns the TurboSound chip-select register and returns read data.
- Sits between the port decoder and the YM pins; replaces direct decoding of BDIR/BC1 from IORQ/WR/RD.

Parameters:
SETUP_CYC, 1, cycles DA is driven with the bus inactive before the strobe (1..15)
STROBE_CYC, 2, cycles the BDIR/BC1 strobe is held for an address or write (1..15)
HOLD_CYC, 1, cycles DA stays driven after the strobe with the bus inactive (0..15)
READ_CYC, 2, cycles of the read strobe before DA is sampled (1..15)

Ports:
cpu_clock  in  1  sole clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller idle and able to accept a request
req_type  in  2  request kind: 00 address latch, 01 data write, 10 data read, 11 reserved (ignored)
req_data  in  8  register number (address) or data byte (write)
rd_data  out  8  byte captured from the YM during a read
rd_valid  out  1  one-cycle pulse; rd_data is valid
bdir  out  1  YM BDIR
bc1  out  1  YM BC1
ym_cs  out  2  one-hot chip enable: 01 selects chip 0, 10 selects chip 1
da_out  out  8  byte driven onto the YM DA bus
da_oe  out  1  DA output enable
da_in  in  8  YM DA bus input

Behaviour:
- Reset (async, high):
  - state IDLE; bdir=0, bc1=0; da_oe=0, da_out=0; rd_data=0, rd_valid=0.
  - chip_sel=0, so ym_cs=01; req_ready=1 once reset deasserts.
  - Assertion mid-access aborts it immediately; bus goes inactive within the same cycle.
- Bus phase encoding (bdir,bc1):
  - inactive = 00; address latch = 11; write = 10; read = 01.
  - Outputs are registered; no other combination is ever driven.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is taken on the edge where req_valid and req_ready are both 1; req_ready drops the following cycle.
  - req_type 11 is accepted and discarded; the controller stays in IDLE and req_ready stays 1.
- TurboSound select:
  - An address request with req_data[7:3]=11111 is not sent to the chips.
  - chip_sel <= req_data[0]; ym_cs updates the next cycle; stays in IDLE; no bus activity.
- FSM states: IDLE, SETUP, STROBE, HOLD, READ.
  - Address or write: IDLE -> SETUP (SETUP_CYC) -> STROBE (STROBE_CYC) -> HOLD (HOLD_CYC; skipped if 0) -> IDLE.
  - In SETUP and HOLD: bus inactive, da_oe=1, da_out=req_data.
  - In STROBE: bus=11 (address) or 10 (write), da_oe=1.
  - Read: IDLE -> READ (READ_CYC) -> IDLE, with bus=01 and da_oe=0 throughout.
  - Read capture: rd_data <= da_in on the last READ cycle's edge; rd_valid=1 for exactly the first IDLE cycle.
- Latency with defaults:
  - Address/write: 4 busy cycles; req_ready returns on cycle 5 after acceptance.
  - Read: rd_valid on cycle 3 after acceptance.
- ym_cs is stable for the whole access. chip_sel changes only in IDLE, so there is no mid-access switch.
- Phase counter: 4-bit, loaded with (N-1) on entry to each state, decremented each cycle; the state exits at 0.
- Back-to-back requests: a request presented on the same edge req_ready rises is accepted; there are no idle gap cycles beyond that.

Decomposition:
- Package ym_bus_pkg:
  - FSM state enum.
  - Bus phase constants BUS_IDLE/BUS_ADDR/BUS_WR/BUS_RD as {bdir,bc1}.
  - req_type codes REQ_ADDR/REQ_WR/REQ_RD.
  - TS_PREFIX = 5'b11111.
- One sub-module, ym_phase_timer:
  - Loadable 4-bit down-counter with a done flag.
  - Instantiated once and shared by all timed states.

Test Plan:
- Reset, then address request 0x07 -> 1 cycle da_oe=1/bus 00, 2 cycles bus=11 with da_out=07, 1 cycle hold, req_ready=1 on the 5th cycle; ym_cs=01 throughout.
- Address 0xFF, then write 0x3E -> ym_cs=10 one cycle after the select, no strobe for 0xFF; write strobe bus=10 with da_out=3E under ym_cs=10; then address 0xFE -> ym_cs=01.
- Read with da_in=0xA5 -> bus=01 for 2 cycles with da_oe=0; rd_valid single pulse with rd_data=A5; bus inactive after.
- req_valid held high across 3 queued writes -> each accepted exactly when req_ready=1; strobes never overlap; no stray 11/01 phases.
- reset asserted during the STROBE of a write -> bdir=bc1=0, da_oe=0, ym_cs=01 immediately; after release the next request runs normally.
- Parameters SETUP_CYC=3, STROBE_CYC=5, HOLD_CYC=0 -> phase lengths 3/5/0 cycles; req_ready returns 8 cycles after acceptance.

Source files
------------

// File: rtl/ym_bus_pkg.sv
// Shared types and constants for the YM2149 TurboSound bus controller.
package ym_bus_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_READ
    } state_t;

    // Bus phases as {bdir, bc1}
    localparam logic [1:0] BUS_IDLE = 2'b00;
    localparam logic [1:0] BUS_ADDR = 2'b11;
    localparam logic [1:0] BUS_WR   = 2'b10;
    localparam logic [1:0] BUS_RD   = 2'b01;

    localparam logic [1:0] REQ_ADDR = 2'b00;
    localparam logic [1:0] REQ_WR   = 2'b01;
    localparam logic [1:0] REQ_RD   = 2'b10;

    localparam logic [4:0] TS_PREFIX = 5'b11111;

endpackage

// File: rtl/ym_phase_timer.sv
// Loadable down-counter timing each bus phase; done_c is high while the count is zero.
module ym_phase_timer
    import ym_bus_pkg::*;
(
    input  logic             cpu_clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/ym_bus_ctrl.sv
// Sequences address/write/read accesses onto the YM2149 BDIR/BC1/DA bus
// and owns the TurboSound chip-select register.
module ym_bus_ctrl
    import ym_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned READ_CYC   = 2
) (
    input  logic              cpu_clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [DATA_W-1:0] req_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              bdir,
    output logic              bc1,
    output logic [1:0]        ym_cs,
    output logic [DATA_W-1:0] da_out,
    output logic              da_oe,
    input  logic [DATA_W-1:0] da_in
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              is_wr_q, is_wr_nxt;
    logic              chip_sel, sel_nxt;
    logic              load;
    logic [CNT_W-1:0]  load_val;
    logic              done_c;
    logic              capture;
    logic [1:0]        bus_nxt;
    logic              oe_nxt;

    ym_phase_timer u_timer (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .load      (load),
        .load_val  (load_val),
        .done_c    (done_c)
    );

    // Next state, phase timer loads and the bus values for the coming cycle
    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        is_wr_nxt = is_wr_q;
        sel_nxt   = chip_sel;
        load      = 1'b0;
        load_val  = '0;
        capture   = 1'b0;
        bus_nxt   = BUS_IDLE;
        oe_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_type == REQ_ADDR && req_data[7:3] == TS_PREFIX) begin
                        sel_nxt = req_data[0];
                    end else if (req_type == REQ_ADDR || req_type == REQ_WR) begin
                        state_nxt = ST_SETUP;
                        load      = 1'b1;
                        load_val  = CNT_W'(SETUP_CYC - 1);
                        data_nxt  = req_data;
                        is_wr_nxt = (req_type == REQ_WR);
                    end else if (req_type == REQ_RD) begin
                        state_nxt = ST_READ;
                        load      = 1'b1;
                        load_val  = CNT_W'(READ_CYC - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (done_c) begin
                    state_nxt = ST_STROBE;
                    load      = 1'b1;
                    load_val  = CNT_W'(STROBE_CYC - 1);
                end
            end
            ST_STROBE: begin
                if (done_c) begin
                    if (HOLD_CYC == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_HOLD;
                        load      = 1'b1;
                        load_val  = CNT_W'(HOLD_CYC - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (done_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                if (done_c) begin
                    state_nxt = ST_IDLE;
                    capture   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        case (state_nxt)
            ST_SETUP, ST_HOLD: oe_nxt = 1'b1;
            ST_STROBE: begin
                oe_nxt  = 1'b1;
                bus_nxt = is_wr_nxt ? BUS_WR : BUS_ADDR;
            end
            ST_READ: bus_nxt = BUS_RD;
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            is_wr_q   <= 1'b0;
            chip_sel  <= 1'b0;
            req_ready <= 1'b1;
            bdir      <= 1'b0;
            bc1       <= 1'b0;
            da_oe     <= 1'b0;
            da_out    <= '0;
            ym_cs     <= 2'b01;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            data_q    <= data_nxt;
            is_wr_q   <= is_wr_nxt;
            chip_sel  <= sel_nxt;
            req_ready <= (state_nxt == ST_IDLE);
            {bdir, bc1} <= bus_nxt;
            da_oe     <= oe_nxt;
            da_out    <= oe_nxt ? data_nxt : '0;
            ym_cs     <= sel_nxt ? 2'b10 : 2'b01;
            rd_valid  <= capture;
            if (capture) begin
                rd_data <= da_in;
            end
        end
    end

endmodule
